// File: rtl/ifd_fetch_decode.sv
// PDP-8 instruction fetch/decode unit: fetches the word at PC_value and issues one-hot opcodes.
// Optional feature: define IFD_LATCH_HALT_EN to latch into a HALTED state after an issued HLT.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef START_ADDRESS
`define START_ADDRESS 12'o0200
`endif

`ifndef IAC
`define IAC     12'o7001
`define RAL     12'o7004
`define RTL     12'o7006
`define RAR     12'o7010
`define RTR     12'o7012
`define CML     12'o7020
`define CMA     12'o7040
`define CIA     12'o7041
`define CLL     12'o7100
`define CLA1    12'o7200
`define CLA_CLL 12'o7300
`define HLT     12'o7402
`define OSR     12'o7404
`define SKP     12'o7410
`define SNL     12'o7420
`define SZL     12'o7430
`define SZA     12'o7440
`define SNA     12'o7450
`define SMA     12'o7500
`define SPA     12'o7510
`define CLA2    12'o7600
`endif

package ifd_pkg;
   typedef struct packed {
      logic       AND;
      logic       TAD;
      logic       ISZ;
      logic       DCA;
      logic       JMS;
      logic       JMP;
      logic [8:0] mem_inst_addr;
   } pdp_mem_opcode_s;

   typedef struct packed {
      logic NOP;
      logic IAC;
      logic RAL;
      logic RTL;
      logic RAR;
      logic RTR;
      logic CML;
      logic CMA;
      logic CIA;
      logic CLL;
      logic CLA1;
      logic CLA_CLL;
      logic HLT;
      logic OSR;
      logic SKP;
      logic SNL;
      logic SZL;
      logic SZA;
      logic SNA;
      logic SMA;
      logic SPA;
      logic CLA2;
   } pdp_op7_opcode_s;
endpackage

module ifd_fetch_decode
   import ifd_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset_n,
   output logic                   ifu_rd_req,
   output logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
   input  logic [`DATA_WIDTH-1:0] ifu_rd_data,
   output logic [`ADDR_WIDTH-1:0] base_addr,
   output pdp_mem_opcode_s        pdp_mem_opcode,
   output pdp_op7_opcode_s        pdp_op7_opcode,
   input  logic                   stall,
   input  logic [`ADDR_WIDTH-1:0] PC_value
);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, BUSY, CLEAR, HALTED} state_t;

   state_t state;
`ifdef IFD_LATCH_HALT_EN
   logic halt_pending;
`endif

   assign base_addr = `START_ADDRESS;

   // NOTE: each decode result starts from all-zero so no path leaves a field unassigned.
   function automatic pdp_mem_opcode_s decode_mem(input logic [`DATA_WIDTH-1:0] word);
      pdp_mem_opcode_s m;
      m = '0;
      case (word[11:9])
         3'd0:    m.AND = 1'b1;
         3'd1:    m.TAD = 1'b1;
         3'd2:    m.ISZ = 1'b1;
         3'd3:    m.DCA = 1'b1;
         3'd4:    m.JMS = 1'b1;
         3'd5:    m.JMP = 1'b1;
         default: ;
      endcase
      if (word[11:9] < 3'd6) m.mem_inst_addr = word[8:0];
      return m;
   endfunction

   function automatic pdp_op7_opcode_s decode_op7(input logic [`DATA_WIDTH-1:0] word);
      pdp_op7_opcode_s o;
      o = '0;
      if (word[11:9] == 3'd7) begin
         case (word)
            `IAC:     o.IAC     = 1'b1;
            `RAL:     o.RAL     = 1'b1;
            `RTL:     o.RTL     = 1'b1;
            `RAR:     o.RAR     = 1'b1;
            `RTR:     o.RTR     = 1'b1;
            `CML:     o.CML     = 1'b1;
            `CMA:     o.CMA     = 1'b1;
            `CIA:     o.CIA     = 1'b1;
            `CLL:     o.CLL     = 1'b1;
            `CLA1:    o.CLA1    = 1'b1;
            `CLA_CLL: o.CLA_CLL = 1'b1;
            `HLT:     o.HLT     = 1'b1;
            `OSR:     o.OSR     = 1'b1;
            `SKP:     o.SKP     = 1'b1;
            `SNL:     o.SNL     = 1'b1;
            `SZL:     o.SZL     = 1'b1;
            `SZA:     o.SZA     = 1'b1;
            `SNA:     o.SNA     = 1'b1;
            `SMA:     o.SMA     = 1'b1;
            `SPA:     o.SPA     = 1'b1;
            `CLA2:    o.CLA2    = 1'b1;
            default:  o.NOP     = 1'b1;
         endcase
      end else if (word[11:9] == 3'd6) begin
         o.NOP = 1'b1;   // IOT is not executed by this core
      end
      return o;
   endfunction

   // NOTE: reset is synchronous, so it only acts on a clock edge; all state uses <= to avoid races.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         ifu_rd_req     <= 1'b0;
         ifu_rd_addr    <= '0;
         pdp_mem_opcode <= '0;
         pdp_op7_opcode <= '0;
`ifdef IFD_LATCH_HALT_EN
         halt_pending   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (!stall) begin
               state       <= FETCH;
               ifu_rd_req  <= 1'b1;
               ifu_rd_addr <= PC_value;
            end
            FETCH: begin
               state      <= LOAD;
               ifu_rd_req <= 1'b0;
            end
            // The flag registers act as the decoded instruction register.
            LOAD: begin
               state          <= ISSUE;
               pdp_mem_opcode <= decode_mem(ifu_rd_data);
               pdp_op7_opcode <= decode_op7(ifu_rd_data);
            end
            ISSUE: if (stall) state <= BUSY;
            BUSY: if (!stall) begin
               state          <= CLEAR;
               pdp_mem_opcode <= '0;
               pdp_op7_opcode <= '0;
`ifdef IFD_LATCH_HALT_EN
               halt_pending   <= pdp_op7_opcode.HLT;
`endif
            end
            CLEAR: begin
`ifdef IFD_LATCH_HALT_EN
               if (halt_pending) begin
                  state <= HALTED;
               end else begin
                  state       <= FETCH;
                  ifu_rd_req  <= 1'b1;
                  ifu_rd_addr <= PC_value;
               end
`else
               state       <= FETCH;
               ifu_rd_req  <= 1'b1;
               ifu_rd_addr <= PC_value;
`endif
            end
            HALTED: state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifd_fetch_decode.sv
// Scoreboard bench for ifd_fetch_decode: directed instruction words with hand-decoded expectations.
module tb_ifd_fetch_decode;
   import ifd_pkg::*;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            ifu_rd_req;
   logic [11:0]     ifu_rd_addr;
   logic [11:0]     ifu_rd_data;
   logic [11:0]     base_addr;
   pdp_mem_opcode_s pdp_mem_opcode;
   pdp_op7_opcode_s pdp_op7_opcode;
   logic            stall;
   logic [11:0]     PC_value;

   int checks = 0;
   int errors = 0;

   logic [11:0] mem [0:4095];

   typedef struct {
      logic [11:0]     addr;
      pdp_mem_opcode_s m;
      pdp_op7_opcode_s o;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [11:0]     addr;
      logic [11:0]     word;
      pdp_mem_opcode_s m;
      pdp_op7_opcode_s o;
      int              dwell;
      int              hold;
   } vec_t;
   vec_t vecs[$];

   ifd_fetch_decode dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ifu_rd_req     (ifu_rd_req),
      .ifu_rd_addr    (ifu_rd_addr),
      .ifu_rd_data    (ifu_rd_data),
      .base_addr      (base_addr),
      .pdp_mem_opcode (pdp_mem_opcode),
      .pdp_op7_opcode (pdp_op7_opcode),
      .stall          (stall),
      .PC_value       (PC_value)
   );

   always #5 clk = ~clk;

   // Memory answers the cycle after a sampled request; idle cycles return a NOP-decoding filler.
   always @(posedge clk) ifu_rd_data <= ifu_rd_req ? mem[ifu_rd_addr] : 12'o7777;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: each fetch pops one expectation; flags are compared two cycles later.
   initial begin
      exp_t cur;
      int   cnt = 0;
      logic prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  check("issue_flags", {pdp_mem_opcode, pdp_op7_opcode}, {cur.m, cur.o});
                  check("one_hot", 64'($countones({pdp_mem_opcode[14:9], pdp_op7_opcode})), 64'd1);
               end
            end
            if (prev_req) begin
               check("req_pulse", ifu_rd_req, 1'b0);
            end else if (ifu_rd_req) begin
               if (sb.size() == 0) begin
                  check("unexpected_fetch", 1'b1, 1'b0);
               end else begin
                  cur = sb.pop_front();
                  check("fetch_addr", ifu_rd_addr, cur.addr);
                  check("fetch_opcodes_zero", {pdp_mem_opcode, pdp_op7_opcode}, 64'd0);
                  cnt = 2;
               end
            end
         end
         prev_req = reset_n ? ifu_rd_req : 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mk(input logic [11:0] addr, input logic [11:0] word,
                               input pdp_mem_opcode_s m, input pdp_op7_opcode_s o,
                               input int dwell, input int hold);
      vec_t v;
      v.addr = addr; v.word = word; v.m = m; v.o = o; v.dwell = dwell; v.hold = hold;
      return v;
   endfunction

   // Releases stall, checks fetch latency, and leaves the DUT in BUSY with stall=1.
   task automatic issue(input vec_t v, input bit from_idle);
      exp_t e;
      e.addr = v.addr; e.m = v.m; e.o = v.o;
      mem[v.addr] = v.word;
      PC_value    = v.addr;
      sb.push_back(e);
      stall = 1'b0;
      @(negedge clk);
      if (!from_idle) begin
         check("clear_flags_zero", {pdp_mem_opcode, pdp_op7_opcode}, 64'd0);
         check("clear_no_req", ifu_rd_req, 1'b0);
         @(negedge clk);
      end
      check("fetch_latency", ifu_rd_req, 1'b1);
      PC_value = v.addr ^ 12'o7777;
      @(negedge clk);
      @(negedge clk);
      check("addr_ignores_pc", ifu_rd_addr, v.addr);
      repeat (v.dwell) begin
         @(negedge clk);
         check("issue_dwell", {ifu_rd_req, pdp_mem_opcode, pdp_op7_opcode}, {1'b0, v.m, v.o});
      end
      stall = 1'b1;
      repeat (v.hold) begin
         @(negedge clk);
         check("busy_hold", {pdp_mem_opcode, pdp_op7_opcode}, {v.m, v.o});
      end
   endtask

   initial begin
      pdp_mem_opcode_s m;
      pdp_op7_opcode_s o;

      m = '0; o = '0; m.TAD = 1'b1; m.mem_inst_addr = 9'o234;
      vecs.push_back(mk(12'o0200, 12'o1234, m, o, 0, 1));
      m = '0; o = '0; o.CIA = 1'b1;
      vecs.push_back(mk(12'o0201, 12'o7041, m, o, 3, 1));
      m = '0; o = '0; o.NOP = 1'b1;
      vecs.push_back(mk(12'o0202, 12'o7000, m, o, 0, 1));
      vecs.push_back(mk(12'o0203, 12'o6001, m, o, 0, 2));
      vecs.push_back(mk(12'o0204, 12'o7777, m, o, 0, 1));
      m = '0; o = '0; m.AND = 1'b1; m.mem_inst_addr = 9'o057;
      vecs.push_back(mk(12'o0205, 12'o0057, m, o, 0, 1));
      m = '0; o = '0; m.ISZ = 1'b1; m.mem_inst_addr = 9'o377;
      vecs.push_back(mk(12'o0206, 12'o2377, m, o, 1, 1));
      m = '0; o = '0; m.JMS = 1'b1; m.mem_inst_addr = 9'o125;
      vecs.push_back(mk(12'o0207, 12'o4125, m, o, 0, 1));
      m = '0; o = '0; o.RAL = 1'b1;
      vecs.push_back(mk(12'o0210, 12'o7004, m, o, 0, 1));
      m = '0; o = '0; o.CLA_CLL = 1'b1;
      vecs.push_back(mk(12'o0211, 12'o7300, m, o, 0, 1));
      m = '0; o = '0; o.SMA = 1'b1;
      vecs.push_back(mk(12'o0212, 12'o7500, m, o, 0, 1));
      m = '0; o = '0; o.CLA2 = 1'b1;
      vecs.push_back(mk(12'o1000, 12'o7600, m, o, 0, 1));
      m = '0; o = '0; m.JMP = 1'b1; m.mem_inst_addr = 9'o020;
      vecs.push_back(mk(12'o0213, 12'o5020, m, o, 0, 10));

      reset_n  = 1'b0;
      stall    = 1'b1;
      PC_value = 12'o0000;
      repeat (3) @(negedge clk);
      check("reset_req", ifu_rd_req, 1'b0);
      check("reset_addr", ifu_rd_addr, 12'o0000);
      check("reset_base_addr", base_addr, 12'o0200);
      check("reset_opcodes", {pdp_mem_opcode, pdp_op7_opcode}, 64'd0);

      reset_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("stall_idle_no_req", ifu_rd_req, 1'b0);
      end

      foreach (vecs[i]) issue(vecs[i], i == 0);

      // Reset during BUSY with DCA active.
      m = '0; o = '0; m.DCA = 1'b1; m.mem_inst_addr = 9'o177;
      issue(mk(12'o0300, 12'o3177, m, o, 0, 2), 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst_opcodes", {pdp_mem_opcode, pdp_op7_opcode}, 64'd0);
      check("midrst_req", ifu_rd_req, 1'b0);
      check("midrst_addr", ifu_rd_addr, 12'o0000);
      check("midrst_base_addr", base_addr, 12'o0200);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midrst_idle_no_req", ifu_rd_req, 1'b0);
      end

      m = '0; o = '0; o.IAC = 1'b1;
      issue(mk(12'o0400, 12'o7001, m, o, 0, 1), 1'b1);
      m = '0; o = '0; o.HLT = 1'b1;
      issue(mk(12'o0401, 12'o7402, m, o, 0, 1), 1'b0);
`ifdef IFD_LATCH_HALT_EN
      stall = 1'b0;
      @(negedge clk);
      check("halt_clear_zero", {pdp_mem_opcode, pdp_op7_opcode}, 64'd0);
      repeat (20) begin
         @(negedge clk);
         check("halted_quiet", {ifu_rd_req, pdp_mem_opcode, pdp_op7_opcode}, 64'd0);
      end
`else
      m = '0; o = '0; o.SZA = 1'b1;
      issue(mk(12'o0402, 12'o7440, m, o, 0, 1), 1'b0);
`endif

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
